// File: rtl/seven_seg_mode_ctrl_if.sv
// rtl/seven_seg_mode_ctrl_if.sv - button, camera-value and display-select signals of the mode sequencer
interface seven_seg_mode_ctrl_if;
  logic       btnNext;
  logic [3:0] isoValue;
  logic [3:0] shutterSpeedValue;
  logic [3:0] focalLenghtValue;
  logic [2:0] brightnessIndicatorValue;
  logic [1:0] selectInput;
  logic       overrideActive;

  // Drives the button and camera values, observes the display select
  modport master (
    output btnNext, isoValue, shutterSpeedValue, focalLenghtValue, brightnessIndicatorValue,
    input  selectInput, overrideActive
  );

  // The sequencer itself
  modport slave (
    input  btnNext, isoValue, shutterSpeedValue, focalLenghtValue, brightnessIndicatorValue,
    output selectInput, overrideActive
  );
endinterface

// File: rtl/seven_seg_mode_ctrl.sv
// rtl/seven_seg_mode_ctrl.sv - display-mode sequencer driving the seven_seg parameter select
module seven_seg_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned CNT_W           = 27
) (
  input logic                  clk,
  input logic                  rstn,
  seven_seg_mode_ctrl_if.slave bus
);

  typedef enum logic {
    ST_USER     = 1'b0,
    ST_OVERRIDE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_deb_level, r_deb_level_d, r_next_pulse;
  logic [CNT_W-1:0] r_deb_cnt;

  logic [3:0]       r_iso_q, r_shut_q, r_focal_q;
  logic [2:0]       r_bright_q;
  logic             r_primed;
  logic             w_chg;
  logic [1:0]       w_chg_idx;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_user_sel, w_user_sel_nxt;
  logic [1:0]       r_ov_sel, w_ov_sel_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [1:0]       r_select, w_select_nxt;
  logic             r_override;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btnNext;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new button level only after it has differed for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else if (r_sync2 == r_deb_level) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb_level <= r_sync2;
      r_deb_cnt   <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // One-cycle step request on each debounced press; releases are ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_deb_level_d <= 1'b0;
      r_next_pulse  <= 1'b0;
    end else begin
      r_deb_level_d <= r_deb_level;
      r_next_pulse  <= r_deb_level & ~r_deb_level_d;
    end
  end

  // Last-cycle copies of the camera values; the first cycle after reset only primes them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_iso_q    <= '0;
      r_shut_q   <= '0;
      r_focal_q  <= '0;
      r_bright_q <= '0;
      r_primed   <= 1'b0;
    end else begin
      r_iso_q    <= bus.isoValue;
      r_shut_q   <= bus.shutterSpeedValue;
      r_focal_q  <= bus.focalLenghtValue;
      r_bright_q <= bus.brightnessIndicatorValue;
      r_primed   <= 1'b1;
    end
  end

  // Flag a value change, lowest parameter index winning when several move together
  always_comb begin
    w_chg     = 1'b0;
    w_chg_idx = 2'd0;
    if (r_primed) begin
      if (bus.isoValue != r_iso_q) begin
        w_chg     = 1'b1;
        w_chg_idx = 2'd0;
      end else if (bus.shutterSpeedValue != r_shut_q) begin
        w_chg     = 1'b1;
        w_chg_idx = 2'd1;
      end else if (bus.focalLenghtValue != r_focal_q) begin
        w_chg     = 1'b1;
        w_chg_idx = 2'd2;
      end else if (bus.brightnessIndicatorValue != r_bright_q) begin
        w_chg     = 1'b1;
        w_chg_idx = 2'd3;
      end
    end
  end

  // Next-state logic: user stepping, override entry, retrigger, cancel and expiry
  always_comb begin
    w_state_nxt    = r_state;
    w_user_sel_nxt = r_user_sel;
    w_ov_sel_nxt   = r_ov_sel;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_USER: begin
        if (r_next_pulse) begin
          w_user_sel_nxt = r_user_sel + 2'd1;
        end
        if (w_chg) begin
          w_state_nxt    = ST_OVERRIDE;
          w_ov_sel_nxt   = w_chg_idx;
          w_hold_cnt_nxt = HOLD_LAST;
        end
      end
      ST_OVERRIDE: begin
        if (r_next_pulse) begin
          w_state_nxt = ST_USER;
        end else if (w_chg) begin
          w_ov_sel_nxt   = w_chg_idx;
          w_hold_cnt_nxt = HOLD_LAST;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = ST_USER;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_USER;
      end
    endcase
    w_select_nxt = (w_state_nxt == ST_OVERRIDE) ? w_ov_sel_nxt : w_user_sel_nxt;
  end

  // State and registered outputs move on the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_USER;
      r_user_sel <= 2'd0;
      r_ov_sel   <= 2'd0;
      r_hold_cnt <= '0;
      r_select   <= 2'd0;
      r_override <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_user_sel <= w_user_sel_nxt;
      r_ov_sel   <= w_ov_sel_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_select   <= w_select_nxt;
      r_override <= (w_state_nxt == ST_OVERRIDE);
    end
  end

  assign bus.selectInput    = r_select;
  assign bus.overrideActive = r_override;

endmodule

// File: doc/seven_seg_mode_ctrl.md
# seven_seg_mode_ctrl

Display-mode sequencer that drives the 2-bit `selectInput` of the `seven_seg` display controller. A debounced front-panel button steps the displayed camera parameter (ISO → shutter → focal → brightness → ISO). Any change to a camera value temporarily forces the display to that parameter for a hold period, then returns to the user's choice.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a button level; must be ≥2.
- `HOLD_CYCLES`, default 100000000: override duration in clock cycles; must be ≥2.
- `CNT_W`, default 27: width of both counters; must hold `HOLD_CYCLES-1` and `DEBOUNCE_CYCLES-1`.
- `clk`  in  1  system clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `btnNext`  in  1  raw, asynchronous, active-high push button.
- `isoValue`  in  4  camera ISO code.
- `shutterSpeedValue`  in  4  camera shutter-speed code.
- `focalLenghtValue`  in  4  camera focal-length code.
- `brightnessIndicatorValue`  in  3  camera brightness-indicator code.
- `selectInput`  out  2  registered parameter select to `seven_seg`: 0 ISO, 1 shutter, 2 focal, 3 brightness.
- `overrideActive`  out  1  registered; high while in OVERRIDE.

## Operation
- Reset values: `selectInput`=0, `overrideActive`=0, `userSel`=0, state USER, both counters 0, synchronizers and debounced level 0, `primed`=0.
- Button path:
  - `btnNext` passes through a 2-FF synchronizer.
  - Debounce counter: cleared while the synchronized value equals the debounced level; otherwise it increments.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the values still differ, the debounced level takes the synchronized value and the counter clears.
  - A rising edge of the debounced level produces a registered 1-cycle `nextPulse`. Release produces no pulse.
- Change detector:
  - Registered copies of the four value inputs are loaded every cycle.
  - The first cycle after reset only loads the copies and sets `primed`. No event is raised.
  - Once primed, any input that differs from its copy raises `chg`, with index `chgIdx`.
  - Priority when several inputs change together: ISO(0) > shutter(1) > focal(2) > brightness(3).
- FSM:
  - USER:
    - `selectInput`=`userSel`.
    - `nextPulse`: `userSel` := `userSel`+1, mod 4, so 3 wraps to 0.
    - `chg`: go to OVERRIDE, `ovSel`:=`chgIdx`, hold counter := `HOLD_CYCLES-1`.
    - Both in the same cycle: apply both. `userSel` increments and the FSM enters OVERRIDE.
  - OVERRIDE:
    - `selectInput`=`ovSel`.
    - Hold counter decrements each cycle.
    - `chg` (any index): reload the counter and update `ovSel`. Retriggering is unlimited.
    - `nextPulse`: return to USER immediately. `userSel` does not change, so the press only cancels the override.
    - `nextPulse` and `chg` in the same cycle: `nextPulse` wins and `chg` is dropped.
    - Counter at 0 with no `chg`: return to USER.
    - Counter at 0 with `chg` in the same cycle: the `chg` reload wins.
- Outputs are registered from next-state logic, so they change on the same edge as the state.
- Reset asserted mid-operation: all state returns immediately to reset values, including mid-debounce and mid-override. After release the first cycle re-primes without raising an event.

## Timing
- Button latency: raw rise sampled at edge 1.
  - Edges 1–2: synchronizer.
  - Edge `DEBOUNCE_CYCLES+2`: debounced level rises.
  - Edge +3: `nextPulse` high for one cycle.
  - Edge `DEBOUNCE_CYCLES+4`: `selectInput` updates.
- Pulse rejection: any raw pulse or bounce that stays stable for fewer than `DEBOUNCE_CYCLES` synchronized samples is ignored.
- Change latency: a value changes before edge n. At edge n, `selectInput`=`ovSel` and `overrideActive`=1.
- Hold: the override stays through edge n+`HOLD_CYCLES`-1. At edge n+`HOLD_CYCLES`, `selectInput` returns to `userSel` and `overrideActive`=0.
- Throughput: a new button press is accepted only after a debounced release, i.e. at most one step per press-release pair.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10.
- Reset state and nonzero inputs:
  - Hold `rstn`=0, then release with ISO=5 and other inputs constant.
  - Required: `selectInput`=0 and `overrideActive`=0 throughout; no override occurs.
- Clean press and wrap:
  - Four clean presses (each high for 20 cycles, low for 20 cycles).
  - Required: `selectInput` steps 1, 2, 3, 0.
  - Each step occurs exactly 8 edges after the raw rise.
- Bounce rejection:
  - Pulses of 1, 2 and 3 cycles, separated by lows.
  - Required: `selectInput` never changes.
  - Then a 6-cycle high: exactly one step.
- Override and expiry:
  - From `userSel`=1, change focal from 2 to 3 before edge n.
  - Required: `selectInput`=2 and `overrideActive`=1 at edge n.
  - Then `selectInput`=1 and `overrideActive`=0 at edge n+10.
- Priority and retrigger:
  - Change ISO and brightness in the same cycle. Required: `selectInput`=0.
  - 6 cycles later, change shutter. Required: `selectInput`=1, and the override lasts 10 further cycles from that change.
- Cancel, simultaneity, async reset:
  - During OVERRIDE, align `nextPulse` with a focal change. Required: USER, `userSel` unchanged.
  - Drive a second `chg` exactly on the counter-0 cycle. Required: the override is extended.
  - Assert `rstn` low mid-override. Required: outputs 0 immediately, with no clock edge needed.
